// File: rtl/nibble_stream_packer_if.sv
// Sample-in / byte-out bundle for the nibble packer; master drives samples and
// consumer ready, slave is the packer.
interface nibble_stream_packer_if #(
  parameter int LVL_W = 3
);
  logic             data_valid;
  logic [3:0]       stimulus_stream;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             fragment;

  modport master (
    output data_valid, stimulus_stream, out_ready,
    input  out_data, out_valid, fifo_level, overflow, fragment
  );

  modport slave (
    input  data_valid, stimulus_stream, out_ready,
    output out_data, out_valid, fifo_level, overflow, fragment
  );
endinterface

// File: rtl/nibble_stream_packer.sv
// Recovers one nibble per SAMPLE_PERIOD clocks, packs pairs high-first into bytes
// and buffers them in a first-word-fall-through FIFO with sticky loss flags.
//
// state   | meaning
// S_EMPTY | no nibble pending; next capture becomes the high nibble
// S_HALF  | high nibble held in hi_nib; next capture completes the byte
module nibble_stream_packer #(
  parameter int SAMPLE_PERIOD = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  nibble_stream_packer_if.slave bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PH_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PH_W-1:0]  PH_RELOAD = PH_W'(SAMPLE_PERIOD - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic {S_EMPTY, S_HALF} state_t;

  state_t           state, state_nxt;
  logic [PH_W-1:0]  phase_cnt;
  logic             capture, load_hi, push, frag_set;
  logic [3:0]       hi_nib;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             not_empty, full, pop, wr_en;
  logic             overflow_q, fragment_q;

  // Down-counter: terminal count 0 is the capture slot, so the first valid edge captures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                phase_cnt <= '0;
    else if (!bus.data_valid)    phase_cnt <= '0;
    else if (phase_cnt == '0)    phase_cnt <= PH_RELOAD;
    else                         phase_cnt <= phase_cnt - PH_W'(1);
  end

  assign capture = bus.data_valid && (phase_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (capture)                   state_nxt = S_HALF;
      S_HALF:  if (capture || !bus.data_valid) state_nxt = S_EMPTY;
      default:                                state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    load_hi  = 1'b0;
    push     = 1'b0;
    frag_set = 1'b0;
    case (state)
      S_EMPTY: load_hi  = capture;
      S_HALF: begin
        push     = capture;
        frag_set = !bus.data_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     hi_nib <= '0;
    else if (load_hi) hi_nib <= bus.stimulus_stream;
  end

  assign not_empty = (level != '0);
  assign full      = (level == LVL_FULL);
  assign pop       = not_empty && bus.out_ready;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {hi_nib, bus.stimulus_stream};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      fragment_q <= 1'b0;
    end else begin
      if (push && !wr_en) overflow_q <= 1'b1;
      if (frag_set)       fragment_q <= 1'b1;
    end
  end

  assign bus.out_valid  = not_empty;
  assign bus.out_data   = not_empty ? mem[rd_ptr] : 8'h00;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;
  assign bus.fragment   = fragment_q;
endmodule

// File: tb/tb_nibble_stream_packer.sv
// Directed bench for nibble_stream_packer: main instance at SAMPLE_PERIOD=4 and a
// second instance at SAMPLE_PERIOD=1, both with FIFO_DEPTH=4.
module tb_nibble_stream_packer;
  localparam int SP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];

  nibble_stream_packer_if #(.LVL_W(3)) ifc ();
  nibble_stream_packer_if #(.LVL_W(3)) ifc1 ();

  nibble_stream_packer #(.SAMPLE_PERIOD(SP), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );
  nibble_stream_packer #(.SAMPLE_PERIOD(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(ifc1)
  );

  always #5 clk = ~clk;

  // Record every accepted byte of the main instance with its edge number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && ifc.out_valid && ifc.out_ready) begin
      got_q.push_back(ifc.out_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nibble(input logic [3:0] n);
    ifc.stimulus_stream = n;
    ifc.data_valid = 1'b1;
    repeat (SP) tick();
  endtask

  task automatic end_burst();
    ifc.data_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    ifc.data_valid = 1'b0;
    ifc.stimulus_stream = 4'h0;
    ifc.out_ready = 1'b0;
    ifc1.data_valid = 1'b0;
    ifc1.stimulus_stream = 4'h0;
    ifc1.out_ready = 1'b0;
    #2 reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ifc.out_valid, ifc.fifo_level, ifc.overflow, ifc.fragment, ifc.out_data} !== 14'h0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b lvl=%0d ovf=%b frag=%b data=%h, want all 0",
               ifc.out_valid, ifc.fifo_level, ifc.overflow, ifc.fragment, ifc.out_data);
    end
  endtask

  task automatic test_single_byte();
    do_reset();
    ifc.out_ready = 1'b1;
    ifc.data_valid = 1'b1;
    ifc.stimulus_stream = 4'hA;
    repeat (SP) tick();
    ifc.stimulus_stream = 4'h5;
    tick();
    checks++;
    if ({ifc.out_valid, ifc.out_data, ifc.fifo_level} !== {1'b1, 8'hA5, 3'd1}) begin
      failures++;
      $display("FAIL single_push: got valid=%b data=%h lvl=%0d, want 1 a5 1",
               ifc.out_valid, ifc.out_data, ifc.fifo_level);
    end
    tick();
    checks++;
    if ({ifc.out_valid, ifc.fifo_level} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL single_pop: got valid=%b lvl=%0d, want 0 0", ifc.out_valid, ifc.fifo_level);
    end
    repeat (SP - 2) tick();
    end_burst();
    tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5 || ifc.overflow !== 1'b0 || ifc.fragment !== 1'b0) begin
      failures++;
      $display("FAIL single_summary: got n=%0d ovf=%b frag=%b, want n=1 byte a5 flags 0",
               got_q.size(), ifc.overflow, ifc.fragment);
    end
  endtask

  task automatic test_repeat_values();
    do_reset();
    ifc.out_ready = 1'b1;
    repeat (4) send_nibble(4'h3);
    end_burst();
    repeat (2) tick();
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL repeat_count: got %0d bytes, want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'h33 || got_q[1] !== 8'h33 || (got_cyc[1] - got_cyc[0]) != 2 * SP) begin
        failures++;
        $display("FAIL repeat_bytes: got %h %h spacing %0d, want 33 33 spacing %0d",
                 got_q[0], got_q[1], got_cyc[1] - got_cyc[0], 2 * SP);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [4];
    exp[0] = 8'h01; exp[1] = 8'h23; exp[2] = 8'h45; exp[3] = 8'h67;
    do_reset();
    for (int i = 0; i < 10; i++) send_nibble(4'(i));
    end_burst();
    checks++;
    if ({ifc.fifo_level, ifc.overflow, ifc.out_data, ifc.fragment} !== {3'd4, 1'b1, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL overflow_state: got lvl=%0d ovf=%b head=%h frag=%b, want 4 1 01 0",
               ifc.fifo_level, ifc.overflow, ifc.out_data, ifc.fragment);
    end
    ifc.out_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (got_q.size() != 4 || ifc.fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL overflow_drain_count: got n=%0d lvl=%0d, want 4 0", got_q.size(), ifc.fifo_level);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp[i]) begin
          failures++;
          $display("FAIL overflow_drain[%0d]: got %h, want %h", i, got_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_fragment();
    do_reset();
    ifc.out_ready = 1'b1;
    send_nibble(4'h1);
    send_nibble(4'h2);
    send_nibble(4'h3);
    end_burst();
    tick();
    checks++;
    if (ifc.fragment !== 1'b1 || got_q.size() != 1 || got_q[0] !== 8'h12) begin
      failures++;
      $display("FAIL fragment_flag: got frag=%b n=%0d, want frag=1 single byte 12",
               ifc.fragment, got_q.size());
    end
    send_nibble(4'h4);
    send_nibble(4'h5);
    end_burst();
    tick();
    checks++;
    if (got_q.size() != 2 || got_q[1] !== 8'h45 || ifc.fragment !== 1'b1) begin
      failures++;
      $display("FAIL fragment_resync: got n=%0d last=%h frag=%b, want 2 bytes, last 45, frag 1",
               got_q.size(), got_q[got_q.size()-1], ifc.fragment);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [5];
    exp[0] = 8'h01; exp[1] = 8'h23; exp[2] = 8'h45; exp[3] = 8'h67; exp[4] = 8'h89;
    do_reset();
    for (int i = 0; i < 8; i++) send_nibble(4'(i));
    send_nibble(4'h8);
    ifc.stimulus_stream = 4'h9;
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    checks++;
    if ({ifc.fifo_level, ifc.overflow, ifc.out_data} !== {3'd4, 1'b0, 8'h23}) begin
      failures++;
      $display("FAIL full_push_pop: got lvl=%0d ovf=%b head=%h, want 4 0 23",
               ifc.fifo_level, ifc.overflow, ifc.out_data);
    end
    repeat (SP - 1) tick();
    end_burst();
    ifc.out_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (got_q.size() != 5) begin
      failures++;
      $display("FAIL full_drain_count: got %0d bytes, want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== exp[i]) begin
          failures++;
          $display("FAIL full_drain[%0d]: got %h, want %h", i, got_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_nibble(4'h9);
    end_burst();
    for (int i = 1; i <= 4; i++) send_nibble(4'(i));
    ifc.stimulus_stream = 4'h5;
    tick();
    tick();
    checks++;
    if ({ifc.fifo_level, ifc.fragment} !== {3'd2, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset_setup: got lvl=%0d frag=%b, want 2 1", ifc.fifo_level, ifc.fragment);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ifc.out_valid, ifc.fifo_level, ifc.overflow, ifc.fragment} !== 6'h0) begin
      failures++;
      $display("FAIL mid_reset_async: got valid=%b lvl=%0d ovf=%b frag=%b, want all 0",
               ifc.out_valid, ifc.fifo_level, ifc.overflow, ifc.fragment);
    end
    ifc.data_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    got_q.delete();
    got_cyc.delete();
    ifc.out_ready = 1'b1;
    send_nibble(4'h7);
    send_nibble(4'hE);
    end_burst();
    tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h7E || ifc.fragment !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_resume: got n=%0d frag=%b, want single byte 7e frag 0",
               got_q.size(), ifc.fragment);
    end
  endtask

  task automatic test_period_one();
    do_reset();
    ifc1.out_ready = 1'b1;
    ifc1.data_valid = 1'b1;
    ifc1.stimulus_stream = 4'hA;
    tick();
    ifc1.stimulus_stream = 4'h5;
    tick();
    ifc1.data_valid = 1'b0;
    checks++;
    if ({ifc1.out_valid, ifc1.out_data, ifc1.fifo_level} !== {1'b1, 8'hA5, 3'd1}) begin
      failures++;
      $display("FAIL period1_push: got valid=%b data=%h lvl=%0d, want 1 a5 1",
               ifc1.out_valid, ifc1.out_data, ifc1.fifo_level);
    end
    tick();
    checks++;
    if ({ifc1.out_valid, ifc1.fifo_level, ifc1.overflow, ifc1.fragment} !== 6'h0) begin
      failures++;
      $display("FAIL period1_pop: got valid=%b lvl=%0d ovf=%b frag=%b, want all 0",
               ifc1.out_valid, ifc1.fifo_level, ifc1.overflow, ifc1.fragment);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_repeat_values();
    test_overflow();
    test_fragment();
    test_full_push_pop();
    test_mid_reset();
    test_period_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
